snes_autojoy: RTL and testbench



---
 rtl/snes_autojoy.sv | 213 +++++++++++++++++++++
 tb/tb_snes_autojoy.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snes_autojoy.sv
// snes_autojoy: console-side controller-port initiator.
//
// Purpose:
//   On an auto-read request (start & enable) it pulses the shared latch, clocks
//   BITS serial bits out of both controller ports and captures four pad words
//   (port1/port2, data line 0/1). The words are published atomically on a
//   one-cycle done pulse. When idle, the CPU manual latch/clock strobes pass
//   straight through to the ports with one cycle of latency.
//
// Ports:
//   clk_sys            system clock
//   reset              synchronous, active-low reset
//   start, enable      auto-read request pulse, auto-read enable (sampled with start)
//   man_strb           CPU manual latch level (idle only)
//   man_clk1/man_clk2  CPU read strobes, high drives the port clock low (idle only)
//   joy1_di, joy2_di   serial data [1:0] from port1/port2, active-low
//   joy_strb           latch to both ports
//   joy1_clk, joy2_clk port clocks, idle high
//   busy, done         auto-read in progress, one-cycle completion pulse
//   pad1..pad4         port1 line0, port2 line0, port1 line1, port2 line1 (MSB = first bit)

module snes_autojoy #(
    parameter int unsigned LATCH_LEN   = 128,
    parameter int unsigned HALF_PERIOD = 128,
    parameter int unsigned BITS        = 16
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            start,
    input  logic            enable,
    input  logic            man_strb,
    input  logic            man_clk1,
    input  logic            man_clk2,
    input  logic [1:0]      joy1_di,
    input  logic [1:0]      joy2_di,
    output logic            joy_strb,
    output logic            joy1_clk,
    output logic            joy2_clk,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] pad1,
    output logic [BITS-1:0] pad2,
    output logic [BITS-1:0] pad3,
    output logic [BITS-1:0] pad4
);

    localparam int unsigned CntMax = (LATCH_LEN > HALF_PERIOD) ? LATCH_LEN : HALF_PERIOD;
    localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned BW     = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StHigh,
        StLow,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_d;
    logic [BW-1:0]   r_bit;
    logic [BW-1:0]   w_bit_d;
    logic            w_sample;
    logic [BITS-1:0] r_sh1, r_sh2, r_sh3, r_sh4;

    logic            w_strb_d;
    logic            w_clk1_d;
    logic            w_clk2_d;
    logic            w_busy_d;
    logic            w_done_d;

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_bit_d   = r_bit;
        w_sample  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start && enable) begin
                    w_state_d = StLatch;
                    w_cnt_d   = '0;
                end
            end
            StLatch: begin
                if (r_cnt == CW'(LATCH_LEN - 1)) begin
                    w_state_d = StHigh;
                    w_cnt_d   = '0;
                    w_bit_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StHigh: begin
                if (r_cnt == CW'(HALF_PERIOD - 1)) begin
                    // Sample at the very end of the high phase, just before the falling edge.
                    w_sample  = 1'b1;
                    w_state_d = StLow;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StLow: begin
                if (r_cnt == CW'(HALF_PERIOD - 1)) begin
                    w_cnt_d = '0;
                    if (r_bit == BW'(BITS - 1)) begin
                        w_state_d = StDone;
                    end else begin
                        w_bit_d   = r_bit + 1'b1;
                        w_state_d = StHigh;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with the state.
    always_comb begin
        w_strb_d = 1'b0;
        w_clk1_d = 1'b1;
        w_clk2_d = 1'b1;
        w_busy_d = 1'b0;
        w_done_d = 1'b0;
        unique case (w_state_d)
            StIdle: begin
                w_strb_d = man_strb;
                w_clk1_d = ~man_clk1;
                w_clk2_d = ~man_clk2;
            end
            StLatch: begin
                w_strb_d = 1'b1;
                w_busy_d = 1'b1;
            end
            StHigh: begin
                w_busy_d = 1'b1;
            end
            StLow: begin
                w_clk1_d = 1'b0;
                w_clk2_d = 1'b0;
                w_busy_d = 1'b1;
            end
            StDone: begin
                w_done_d = 1'b1;
            end
            default: begin
                w_strb_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_sh1    <= '0;
            r_sh2    <= '0;
            r_sh3    <= '0;
            r_sh4    <= '0;
            pad1     <= '0;
            pad2     <= '0;
            pad3     <= '0;
            pad4     <= '0;
            joy_strb <= 1'b0;
            joy1_clk <= 1'b1;
            joy2_clk <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_bit    <= w_bit_d;
            joy_strb <= w_strb_d;
            joy1_clk <= w_clk1_d;
            joy2_clk <= w_clk2_d;
            busy     <= w_busy_d;
            done     <= w_done_d;

            if (r_state == StIdle && w_state_d == StLatch) begin
                r_sh1 <= '0;
                r_sh2 <= '0;
                r_sh3 <= '0;
                r_sh4 <= '0;
            end else if (w_sample) begin
                // Lines are active-low; store pressed as 1.
                r_sh1 <= {r_sh1[BITS-2:0], ~joy1_di[0]};
                r_sh2 <= {r_sh2[BITS-2:0], ~joy2_di[0]};
                r_sh3 <= {r_sh3[BITS-2:0], ~joy1_di[1]};
                r_sh4 <= {r_sh4[BITS-2:0], ~joy2_di[1]};
            end

            // Publish all four words together as DONE is entered.
            if (w_state_d == StDone) begin
                pad1 <= r_sh1;
                pad2 <= r_sh2;
                pad3 <= r_sh3;
                pad4 <= r_sh4;
            end
        end
    end

endmodule

// File: tb/tb_snes_autojoy.sv
// tb_snes_autojoy: directed self-checking bench for snes_autojoy.
// Includes a behavioural model of two controllers (4 data lines) that return
// programmable button words, active-low, MSB first, advancing on clock rising edges.

module tb_snes_autojoy;

    logic        clk_sys;
    logic        reset;
    logic        start;
    logic        enable;
    logic        man_strb;
    logic        man_clk1;
    logic        man_clk2;
    logic [1:0]  joy1_di;
    logic [1:0]  joy2_di;
    logic        joy_strb;
    logic        joy1_clk;
    logic        joy2_clk;
    logic        busy;
    logic        done;
    logic [15:0] pad1, pad2, pad3, pad4;

    int n_checks = 0;
    int n_fail   = 0;

    snes_autojoy dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .start    (start),
        .enable   (enable),
        .man_strb (man_strb),
        .man_clk1 (man_clk1),
        .man_clk2 (man_clk2),
        .joy1_di  (joy1_di),
        .joy2_di  (joy2_di),
        .joy_strb (joy_strb),
        .joy1_clk (joy1_clk),
        .joy2_clk (joy2_clk),
        .busy     (busy),
        .done     (done),
        .pad1     (pad1),
        .pad2     (pad2),
        .pad3     (pad3),
        .pad4     (pad4)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Controller model: pressed buttons are 1 in the pattern, driven low on the line.
    logic [15:0] pat1_0, pat1_1, pat2_0, pat2_1;
    int          idx1, idx2;
    logic        prev_c1, prev_c2;

    always @(posedge clk_sys) begin
        if (joy_strb) idx1 <= 0;
        else if (joy1_clk && !prev_c1) idx1 <= idx1 + 1;
        if (joy_strb) idx2 <= 0;
        else if (joy2_clk && !prev_c2) idx2 <= idx2 + 1;
        prev_c1 <= joy1_clk;
        prev_c2 <= joy2_clk;
    end

    always_comb begin
        joy1_di = 2'b00;
        joy2_di = 2'b00;
        if (idx1 >= 0 && idx1 < 16) joy1_di = {~pat1_1[15-idx1], ~pat1_0[15-idx1]};
        if (idx2 >= 0 && idx2 < 16) joy2_di = {~pat2_1[15-idx2], ~pat2_0[15-idx2]};
    end

    // Activity monitor, sampled mid-cycle.
    logic mon_clr;
    int   n_strb, n_low1, n_low2, n_fall1, n_fall2, n_done;
    logic m_c1, m_c2;

    always @(negedge clk_sys) begin
        if (mon_clr) begin
            n_strb  <= 0;
            n_low1  <= 0;
            n_low2  <= 0;
            n_fall1 <= 0;
            n_fall2 <= 0;
            n_done  <= 0;
        end else begin
            if (joy_strb === 1'b1) n_strb <= n_strb + 1;
            if (joy1_clk === 1'b0) n_low1 <= n_low1 + 1;
            if (joy2_clk === 1'b0) n_low2 <= n_low2 + 1;
            if (m_c1 === 1'b1 && joy1_clk === 1'b0) n_fall1 <= n_fall1 + 1;
            if (m_c2 === 1'b1 && joy2_clk === 1'b0) n_fall2 <= n_fall2 + 1;
            if (done === 1'b1) n_done <= n_done + 1;
        end
        m_c1 <= joy1_clk;
        m_c2 <= joy2_clk;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    // Issues start in the current cycle (T) and runs until done or a cycle budget.
    // dcyc = offset of the done cycle from T, or -1; inj = offset of an extra start pulse.
    task automatic run_read(input int inj, input bit drop_en, output int dcyc,
                            output logic [15:0] mid_pad1, output logic busy1,
                            output logic strb1);
        int cyc;
        dcyc     = -1;
        mid_pad1 = 16'hxxxx;
        start    = 1'b1;
        enable   = 1'b1;
        tick();
        start = 1'b0;
        if (drop_en) enable = 1'b0;
        busy1 = busy;
        strb1 = joy_strb;
        cyc   = 1;
        while (cyc < 5000) begin
            if (done === 1'b1) begin
                dcyc = cyc;
                break;
            end
            if (cyc == 2000) mid_pad1 = pad1;
            start = (cyc == inj);
            tick();
            cyc++;
        end
        start  = 1'b0;
        enable = 1'b1;
    endtask

    int          dcyc;
    logic [15:0] mp1;
    logic        b1, s1;

    initial begin
        reset    = 1'b0;
        start    = 1'b1;
        enable   = 1'b1;
        man_strb = 1'b0;
        man_clk1 = 1'b0;
        man_clk2 = 1'b0;
        mon_clr  = 1'b1;
        idx1     = 16;
        idx2     = 16;
        pat1_0   = 16'h5A3C;
        pat1_1   = 16'h0000;
        pat2_0   = 16'h0000;
        pat2_1   = 16'h0000;

        // Reset held with start asserted.
        repeat (3) tick();
        chk("rst_strb", joy_strb, 0);
        chk("rst_clk1", joy1_clk, 1);
        chk("rst_clk2", joy2_clk, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pads", {pad1, pad2}, 0);
        reset = 1'b1;
        start = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_clks", {joy1_clk, joy2_clk, joy_strb}, 3'b110);

        // Full read, with a stray start at T+1000.
        clear_mon();
        run_read(1000, 1'b0, dcyc, mp1, b1, s1);
        chk("read1_busy_t1", b1, 1);
        chk("read1_strb_t1", s1, 1);
        chk("read1_mid_pad1", mp1, 16'h0000);
        chk("read1_done_cyc", dcyc, 4225);
        chk("read1_pad1", pad1, 16'h5A3C);
        chk("read1_pad2", pad2, 16'h0000);
        chk("read1_pad3", pad3, 16'h0000);
        chk("read1_pad4", pad4, 16'h0000);
        chk("read1_busy_done", busy, 0);
        tick();
        chk("read1_done_pulse", done, 0);
        chk("read1_strb_cycles", n_strb, 128);
        chk("read1_clk1_low", n_low1, 2048);
        chk("read1_clk2_low", n_low2, 2048);
        chk("read1_clk1_pulses", n_fall1, 16);
        chk("read1_clk2_pulses", n_fall2, 16);
        chk("read1_done_count", n_done, 1);

        // start with enable low is ignored.
        clear_mon();
        start  = 1'b1;
        enable = 1'b0;
        tick();
        start  = 1'b0;
        enable = 1'b1;
        repeat (300) tick();
        chk("noen_strb", n_strb, 0);
        chk("noen_clk", n_low1 + n_low2, 0);
        chk("noen_busy", busy, 0);
        chk("noen_pad1", pad1, 16'h5A3C);

        // Manual pass-through while idle.
        man_strb = 1'b1;
        man_clk2 = 1'b1;
        tick();
        chk("man_strb", joy_strb, 1);
        chk("man_clk2", joy2_clk, 0);
        chk("man_clk1", joy1_clk, 1);
        man_strb = 1'b0;
        man_clk2 = 1'b0;
        tick();
        chk("man_release", {joy_strb, joy1_clk, joy2_clk}, 3'b011);

        // Manual inputs ignored while busy, then reset mid-read at T+2000.
        clear_mon();
        start = 1'b1;
        tick();
        start    = 1'b0;
        man_strb = 1'b1;
        man_clk1 = 1'b1;
        man_clk2 = 1'b1;
        repeat (48) tick();
        chk("busy_man_latch", {joy_strb, joy1_clk, joy2_clk}, 3'b111);
        repeat (150) tick();
        chk("busy_man_high", {joy_strb, joy1_clk, joy2_clk}, 3'b011);
        man_strb = 1'b0;
        man_clk1 = 1'b0;
        man_clk2 = 1'b0;
        repeat (1801) tick();
        chk("mid_pad1_hold", pad1, 16'h5A3C);
        reset = 1'b0;
        tick();
        chk("abort_outs", {joy_strb, joy1_clk, joy2_clk, busy, done}, 5'b01100);
        chk("abort_pads", {pad1, pad2, pad3, pad4}, 0);
        reset = 1'b1;
        repeat (3) tick();
        chk("abort_no_done", n_done, 0);
        chk("abort_idle", busy, 0);

        // New read after reset completes; enable drops mid-read.
        run_read(0, 1'b1, dcyc, mp1, b1, s1);
        chk("read2_done_cyc", dcyc, 4225);
        chk("read2_pad1", pad1, 16'h5A3C);

        // Back-to-back: start in the cycle after done, new patterns on all lines.
        pat1_0 = 16'h8001;
        pat1_1 = 16'h1234;
        pat2_0 = 16'hC3A5;
        pat2_1 = 16'h0F0F;
        tick();
        chk("b2b_done_low", done, 0);
        run_read(0, 1'b0, dcyc, mp1, b1, s1);
        chk("b2b_busy_t1", b1, 1);
        chk("b2b_mid_pad1", mp1, 16'h5A3C);
        chk("b2b_done_cyc", dcyc, 4225);
        chk("b2b_pad1", pad1, 16'h8001);
        chk("b2b_pad2", pad2, 16'hC3A5);
        chk("b2b_pad3", pad3, 16'h1234);
        chk("b2b_pad4", pad4, 16'h0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
